// File: rtl/matrix_scan_bcm_if.sv
// Pixel-fetch handshake between matrix_scan_bcm (master) and the framebuffer fetch path (slave).
// The master requests (row, column, plane) with clk_pixel_load; the slave answers with pixel_valid.
interface matrix_scan_bcm_if #(
    parameter int COLUMN_WIDTH      = 6,
    parameter int ROW_WIDTH         = 4,
    parameter int BRIGHTNESS_LEVELS = 6
);
    logic [COLUMN_WIDTH-1:0]      column_address;
    logic [ROW_WIDTH-1:0]         row_address;
    logic [BRIGHTNESS_LEVELS-1:0] brightness_mask;
    logic                         clk_pixel_load;
    logic                         pixel_valid;

    modport master (
        output column_address,
        output row_address,
        output brightness_mask,
        output clk_pixel_load,
        input  pixel_valid
    );

    modport slave (
        input  column_address,
        input  row_address,
        input  brightness_mask,
        input  clk_pixel_load,
        output pixel_valid
    );
endinterface

// File: rtl/matrix_scan_bcm.sv
// HUB75 binary-code-modulation scan engine: shifts the next bit plane while the previous one is shown.
// Optional macro MATRIX_GLOBAL_DIM_EN adds dim_level_i, which scales the OE on-time of every plane.
module matrix_scan_bcm #(
    parameter int COLUMNS           = 64,
    parameter int COLUMN_WIDTH      = 6,
    parameter int SCAN_ROWS         = 16,
    parameter int ROW_WIDTH         = 4,
    parameter int BRIGHTNESS_LEVELS = 6,
    parameter int LSB_OE_TICKS      = 2,
    parameter int OE_COUNTER_WIDTH  = 10,
    parameter int BLANK_TICKS       = 2
) (
    input  logic                 clk_in,
    input  logic                 reset,
    input  logic                 enable_i,
`ifdef MATRIX_GLOBAL_DIM_EN
    input  logic [7:0]           dim_level_i,
`endif
    matrix_scan_bcm_if.master    fetch_if,
    output logic [ROW_WIDTH-1:0] row_address_active_o,
    output logic                 clk_pixel_o,
    output logic                 row_latch_o,
    output logic                 output_enable_o,
    output logic                 frame_start_o
);

    localparam int PLANE_W    = (BRIGHTNESS_LEVELS > 1) ? $clog2(BRIGHTNESS_LEVELS) : 1;
    localparam int BLANK_W    = (BLANK_TICKS > 1) ? $clog2(BLANK_TICKS) : 1;
    localparam int BLANK_INIT = (BLANK_TICKS > 1) ? (BLANK_TICKS - 2) : 0;
    localparam int PROD_W     = OE_COUNTER_WIDTH + 9;

    // Parameter sanity: refuse to elaborate configurations the counters cannot represent.
    if ((LSB_OE_TICKS << (BRIGHTNESS_LEVELS - 1)) >= (1 << OE_COUNTER_WIDTH)) begin : g_oe_width_bad
        $error("OE_COUNTER_WIDTH too small for LSB_OE_TICKS << (BRIGHTNESS_LEVELS-1)");
    end
    if (COLUMNS > (1 << COLUMN_WIDTH)) begin : g_col_width_bad
        $error("COLUMNS does not fit in COLUMN_WIDTH");
    end
    if (SCAN_ROWS > (1 << ROW_WIDTH)) begin : g_row_width_bad
        $error("SCAN_ROWS does not fit in ROW_WIDTH");
    end
    if (BLANK_TICKS < 1) begin : g_blank_bad
        $error("BLANK_TICKS must be at least 1 (the latch cycle itself)");
    end

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_WAIT_DATA = 3'd2,
        ST_SHIFT_LO  = 3'd3,
        ST_SHIFT_HI  = 3'd4,
        ST_WAIT_OE   = 3'd5,
        ST_BLANK     = 3'd6,
        ST_LATCH     = 3'd7
    } state_t;

    state_t                        state_q;
    logic [COLUMN_WIDTH-1:0]       column_q;
    logic [ROW_WIDTH-1:0]          row_q;
    logic [ROW_WIDTH-1:0]          row_active_q;
    logic [PLANE_W-1:0]            plane_q;
    logic [BRIGHTNESS_LEVELS-1:0]  mask_q;
    logic [OE_COUNTER_WIDTH-1:0]   timer_q;
    logic [OE_COUNTER_WIDTH-1:0]   thresh_q;
    logic [BLANK_W-1:0]            blank_q;
    logic                          load_q;
    logic                          pix_q;
    logic                          latch_q;
    logic                          oe_q;
    logic                          frame_q;

    logic [OE_COUNTER_WIDTH-1:0]   period_d;
    logic [OE_COUNTER_WIDTH-1:0]   on_time_d;
    logic [OE_COUNTER_WIDTH-1:0]   thresh_d;
`ifdef MATRIX_GLOBAL_DIM_EN
    logic [PROD_W-1:0]             dim_product_s;
`endif

    // Display period of the plane about to be latched and the timer value below which OE drops.
    always_comb begin
        period_d = OE_COUNTER_WIDTH'(LSB_OE_TICKS) << plane_q;
`ifdef MATRIX_GLOBAL_DIM_EN
        dim_product_s = PROD_W'(period_d) * (PROD_W'(dim_level_i) + PROD_W'(1));
        on_time_d     = OE_COUNTER_WIDTH'(dim_product_s >> 4'd8);
`else
        on_time_d     = period_d;
`endif
        thresh_d = period_d - on_time_d;
    end

    // Scan sequencer, OE timer and all registered panel/fetch outputs.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            column_q     <= '0;
            row_q        <= '0;
            row_active_q <= '0;
            plane_q      <= '0;
            mask_q       <= BRIGHTNESS_LEVELS'(1);
            timer_q      <= '0;
            thresh_q     <= '0;
            blank_q      <= '0;
            load_q       <= 1'b0;
            pix_q        <= 1'b0;
            latch_q      <= 1'b0;
            oe_q         <= 1'b0;
            frame_q      <= 1'b0;
        end else begin
            load_q  <= 1'b0;
            pix_q   <= 1'b0;
            latch_q <= 1'b0;
            frame_q <= 1'b0;

            // OE stays high while the remaining period is above the dimming threshold.
            if (timer_q != '0) begin
                timer_q <= timer_q - OE_COUNTER_WIDTH'(1);
                oe_q    <= ((timer_q - OE_COUNTER_WIDTH'(1)) > thresh_q);
            end else begin
                oe_q    <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (enable_i) begin
                        column_q <= '0;
                        load_q   <= 1'b1;
                        state_q  <= ST_LOAD;
                    end else begin
                        state_q  <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    state_q <= ST_WAIT_DATA;
                end
                ST_WAIT_DATA: begin
                    if (fetch_if.pixel_valid) begin
                        state_q <= ST_SHIFT_LO;
                    end else begin
                        state_q <= ST_WAIT_DATA;
                    end
                end
                ST_SHIFT_LO: begin
                    pix_q   <= 1'b1;
                    state_q <= ST_SHIFT_HI;
                end
                ST_SHIFT_HI: begin
                    if (column_q == COLUMN_WIDTH'(COLUMNS - 1)) begin
                        column_q <= '0;
                        state_q  <= ST_WAIT_OE;
                    end else begin
                        column_q <= column_q + COLUMN_WIDTH'(1);
                        load_q   <= 1'b1;
                        state_q  <= ST_LOAD;
                    end
                end
                ST_WAIT_OE: begin
                    // The shifted plane is only latched once the previous plane has had its full period.
                    if (timer_q != '0) begin
                        state_q <= ST_WAIT_OE;
                    end else if (!enable_i) begin
                        state_q <= ST_IDLE;
                    end else if (BLANK_TICKS > 1) begin
                        blank_q <= BLANK_W'(BLANK_INIT);
                        state_q <= ST_BLANK;
                    end else begin
                        latch_q <= 1'b1;
                        frame_q <= (row_q == '0) && (plane_q == '0);
                        state_q <= ST_LATCH;
                    end
                end
                ST_BLANK: begin
                    if (blank_q == '0) begin
                        latch_q <= 1'b1;
                        frame_q <= (row_q == '0) && (plane_q == '0);
                        state_q <= ST_LATCH;
                    end else begin
                        blank_q <= blank_q - BLANK_W'(1);
                        state_q <= ST_BLANK;
                    end
                end
                ST_LATCH: begin
                    row_active_q <= row_q;
                    timer_q      <= period_d;
                    thresh_q     <= thresh_d;
                    oe_q         <= (on_time_d != '0);
                    if (plane_q == PLANE_W'(BRIGHTNESS_LEVELS - 1)) begin
                        plane_q <= '0;
                        mask_q  <= BRIGHTNESS_LEVELS'(1);
                        if (row_q == ROW_WIDTH'(SCAN_ROWS - 1)) begin
                            row_q <= '0;
                        end else begin
                            row_q <= row_q + ROW_WIDTH'(1);
                        end
                    end else begin
                        plane_q <= plane_q + PLANE_W'(1);
                        mask_q  <= mask_q << 1;
                    end
                    load_q  <= 1'b1;
                    state_q <= ST_LOAD;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign fetch_if.column_address  = column_q;
    assign fetch_if.row_address     = row_q;
    assign fetch_if.brightness_mask = mask_q;
    assign fetch_if.clk_pixel_load  = load_q;
    assign row_address_active_o     = row_active_q;
    assign clk_pixel_o              = pix_q;
    assign row_latch_o              = latch_q;
    assign output_enable_o          = oe_q;
    assign frame_start_o            = frame_q;

endmodule

// File: tb/tb_matrix_scan_bcm.sv
// Scoreboard bench for matrix_scan_bcm: 4 columns, 4 scan rows, 3 planes, LSB period 2.
`timescale 1ns/1ps
module tb_matrix_scan_bcm;

    localparam int C  = 4;
    localparam int CW = 2;
    localparam int SR = 4;
    localparam int RW = 2;
    localparam int L  = 3;

    typedef struct {
        int row;
        int col;
        int mask;
        int delta;
    } fetch_t;

    typedef struct {
        int row;
        int mask;
        int fs;
    } latch_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          delay_mode;
    logic          pv_pulse;
    logic [RW-1:0] row_active;
    logic          clk_pixel;
    logic          row_latch;
    logic          oe;
    logic          frame_start;

    fetch_t fq[$];
    latch_t lq[$];
    int     oq[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_load = 0;
    int pix_cnt = 0;
    int oe_run = 0;
    int pend_act = -1;
    int latch_cnt = 0;
    int fs_cnt = 0;
    int saved_latches;
    fetch_t fe;
    latch_t le;
    int oexp;

    matrix_scan_bcm_if #(.COLUMN_WIDTH(CW), .ROW_WIDTH(RW), .BRIGHTNESS_LEVELS(L)) bus ();

    matrix_scan_bcm #(
        .COLUMNS(C), .COLUMN_WIDTH(CW), .SCAN_ROWS(SR), .ROW_WIDTH(RW),
        .BRIGHTNESS_LEVELS(L), .LSB_OE_TICKS(2), .OE_COUNTER_WIDTH(4), .BLANK_TICKS(2)
    ) dut (
        .clk_in               (clk),
        .reset                (reset),
        .enable_i             (enable),
`ifdef MATRIX_GLOBAL_DIM_EN
        .dim_level_i          (8'd255),
`endif
        .fetch_if             (bus.master),
        .row_address_active_o (row_active),
        .clk_pixel_o          (clk_pixel),
        .row_latch_o          (row_latch),
        .output_enable_o      (oe),
        .frame_start_o        (frame_start)
    );

    always #5 clk = ~clk;

    assign bus.pixel_valid = delay_mode ? pv_pulse : 1'b1;

    task automatic check(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Plane index k: row (k/3)%4, plane k%3; one fetch per column.
    task automatic push_fetches(input int k, input int delta);
        for (int c = 0; c < C; c++) begin
            fetch_t f;
            f.row   = (k / L) % SR;
            f.col   = c;
            f.mask  = 1 << (k % L);
            f.delta = (c == 0) ? 0 : delta;
            fq.push_back(f);
        end
    endtask

    task automatic push_latch(input int k);
        latch_t x;
        x.row  = (k / L) % SR;
        x.mask = 1 << (k % L);
        x.fs   = ((x.row == 0) && (k % L == 0)) ? 1 : 0;
        lq.push_back(x);
        oq.push_back(2 << (k % L));
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_load"}, int'(bus.clk_pixel_load), 0);
        check({tag, "_clk_pixel"}, int'(clk_pixel), 0);
        check({tag, "_latch"}, int'(row_latch), 0);
        check({tag, "_oe"}, int'(oe), 0);
        check({tag, "_frame_start"}, int'(frame_start), 0);
        check({tag, "_column"}, int'(bus.column_address), 0);
        check({tag, "_row"}, int'(bus.row_address), 0);
        check({tag, "_row_active"}, int'(row_active), 0);
        check({tag, "_mask"}, int'(bus.brightness_mask), 1);
    endtask

    task automatic wait_latches(input int n, input int budget);
        int t;
        t = 0;
        while (latch_cnt < n && t < budget) begin
            @(negedge clk);
            t = t + 1;
        end
        if (latch_cnt < n) fail("latch_timeout");
    endtask

    // Delayed fetch responder: pixel_valid one cycle, three cycles after each request.
    initial begin
        pv_pulse = 1'b0;
        forever begin
            @(negedge clk);
            if (delay_mode && bus.clk_pixel_load && !reset) begin
                repeat (3) @(posedge clk);
                #1 pv_pulse = 1'b1;
                @(posedge clk);
                #1 pv_pulse = 1'b0;
            end
        end
    end

    // Monitor: pops expected fetches, latches and OE run lengths as the DUT produces them.
    initial begin
        forever begin
            @(negedge clk);
            cyc = cyc + 1;
            if (reset) begin
                pix_cnt  = 0;
                oe_run   = 0;
                pend_act = -1;
            end else begin
                if (pend_act >= 0) begin
                    check("row_active", int'(row_active), pend_act);
                    pend_act = -1;
                end
                if (bus.clk_pixel_load) begin
                    if (fq.size() == 0) begin
                        fail("unexpected_fetch");
                    end else begin
                        fe = fq.pop_front();
                        check("fetch_row", int'(bus.row_address), fe.row);
                        check("fetch_col", int'(bus.column_address), fe.col);
                        check("fetch_mask", int'(bus.brightness_mask), fe.mask);
                        if (fe.delta > 0) check("col_period", cyc - last_load, fe.delta);
                    end
                    last_load = cyc;
                end
                if (clk_pixel) pix_cnt = pix_cnt + 1;
                if (frame_start) fs_cnt = fs_cnt + 1;
                if (row_latch) begin
                    latch_cnt = latch_cnt + 1;
                    check("oe_at_latch", int'(oe), 0);
                    check("pixels_per_latch", pix_cnt, C);
                    pix_cnt = 0;
                    if (lq.size() == 0) begin
                        fail("unexpected_latch");
                    end else begin
                        le = lq.pop_front();
                        check("latch_row", int'(bus.row_address), le.row);
                        check("latch_mask", int'(bus.brightness_mask), le.mask);
                        check("frame_start", int'(frame_start), le.fs);
                        pend_act = le.row;
                    end
                end else if (frame_start) begin
                    fail("frame_start_without_latch");
                end
                if (oe) begin
                    oe_run = oe_run + 1;
                end else if (oe_run > 0) begin
                    if (oq.size() == 0) begin
                        fail("unexpected_oe_run");
                    end else begin
                        oexp = oq.pop_front();
                        check("oe_run", oe_run, oexp);
                    end
                    oe_run = 0;
                end
            end
        end
    end

    initial begin
        reset      = 1'b1;
        enable     = 1'b0;
        delay_mode = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        reset = 1'b0;

        // Free-running fetch: one full frame (12 latches) plus the next row 0 plane 0.
        for (int k = 0; k <= 13; k++) push_fetches(k, 4);
        for (int k = 0; k <= 12; k++) push_latch(k);
        enable = 1'b1;
        wait_latches(13, 1000);
        enable = 1'b0;
        repeat (40) @(negedge clk);
        check("idle_latches", latch_cnt, 13);
        check("frame_starts", fs_cnt, 2);
        check("idle_fetch_left", fq.size(), 0);
        check("idle_oe", int'(oe), 0);
        check("idle_load", int'(bus.clk_pixel_load), 0);
        check("idle_mask_kept", int'(bus.brightness_mask), 2);
        check("idle_row_kept", int'(bus.row_address), 0);

        // Resume with slow fetch: same unlatched plane is reshifted, columns take 6 cycles.
        pix_cnt    = 0;
        delay_mode = 1'b1;
        for (int k = 13; k <= 16; k++) push_fetches(k, 6);
        for (int k = 13; k <= 15; k++) push_latch(k);
        enable = 1'b1;
        wait_latches(16, 1500);
        for (int t = 0; t < 100 && !clk_pixel; t++) @(negedge clk);
        if (!clk_pixel) fail("shift_hi_timeout");
        reset = 1'b1;
        @(negedge clk);
        check_idle("reset_mid_shift");
        fq.delete();
        enable        = 1'b0;
        saved_latches = latch_cnt;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("post_reset_latches", latch_cnt, saved_latches);
        check("post_reset_column", int'(bus.column_address), 0);

        // Restart from reset position, then stop before latching.
        delay_mode = 1'b0;
        push_fetches(0, 4);
        enable = 1'b1;
        for (int t = 0; t < 100 && fq.size() != 0; t++) @(negedge clk);
        enable = 1'b0;
        repeat (30) @(negedge clk);
        check("restart_fetch_left", fq.size(), 0);
        check("restart_latches", latch_cnt, saved_latches);
        check("latch_left", lq.size(), 0);
        check("oe_left", oq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
